char_scroller: RTL and testbench

CHAR_SCROLLER -- requirements
Module: char_scroller

---
 rtl/char_scroller_pkg.sv | 29 ++
 rtl/char_scroller_prescaler.sv | 28 ++
 rtl/char_scroller.sv | 133 +++++++++++++
 tb/tb_char_scroller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_scroller_pkg.sv
// Shared types and character codes for the "dE10" scrolling display.
package char_scroller_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLINK = 2'd2
    } state_e;

    typedef logic [1:0] char_t;

    localparam char_t CH_D = 2'b00;
    localparam char_t CH_E = 2'b01;
    localparam char_t CH_1 = 2'b10;
    localparam char_t CH_0 = 2'b11;

    // Message position (0..3) to the character shown there.
    function automatic char_t char_at(input logic [1:0] pos);
        char_t c;
        case (pos)
            2'd0:    c = CH_D;
            2'd1:    c = CH_E;
            2'd2:    c = CH_1;
            default: c = CH_0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/char_scroller_prescaler.sv
// Rotation-step prescaler: counts 0..TICK_DIV-1 while enabled, pulses tc_c on the last count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_q;

    assign tc_c = enable && (count_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= tc_c ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/char_scroller.sv
// Scrolls the 4-character message "dE10" across NUM_DISP displays, auto or single-step.
// Optional end-of-message blink is enabled by defining SCROLL_BLINK_EN.
module char_scroller
    import char_scroller_pkg::*;
#(
    parameter int unsigned NUM_DISP = 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  step,
    output logic [2*NUM_DISP-1:0] codes,
    output logic                  tick,
    output logic [NUM_DISP-1:0]   blank
);

    state_e               state_q, state_d;
    logic [1:0]           offset_q, offset_d, offset_step_c;
    logic                 step_q;
    logic                 step_rise_c;
    logic                 adv_c;
    logic                 pre_en_c;
    logic                 tc_c;
    logic [2*NUM_DISP-1:0] codes_d;

    // Display i shows message position (offset + NUM_DISP-1-i) mod 4.
    function automatic logic [2*NUM_DISP-1:0] pattern(input logic [1:0] off);
        logic [2*NUM_DISP-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_DISP; i++) begin
            p[2*i +: 2] = char_at(off + 2'(NUM_DISP - 1 - i));
        end
        return p;
    endfunction

`ifdef SCROLL_BLINK_EN
    logic [1:0] period_q;
    assign pre_en_c = (state_q == ST_RUN) || (state_q == ST_BLINK);
`else
    assign pre_en_c = (state_q == ST_RUN);
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (!pre_en_c),
        .enable (pre_en_c),
        .tc_c   (tc_c)
    );

    assign step_rise_c   = step && !step_q;
    assign offset_step_c = dir ? offset_q - 2'd1 : offset_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        adv_c    = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                // A step edge coinciding with run rising is dropped.
                if (run) begin
                    state_d = ST_RUN;
                end else if (step_rise_c) begin
                    adv_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (tc_c) begin
                    adv_c = 1'b1;
                end
                if (!run) begin
                    state_d = ST_PAUSE;
                end
`ifdef SCROLL_BLINK_EN
                if (tc_c && (offset_step_c == 2'd0)) begin
                    state_d = ST_BLINK;
                end
`endif
            end
`ifdef SCROLL_BLINK_EN
            ST_BLINK: begin
                if (tc_c && (period_q == 2'd3)) begin
                    state_d = run ? ST_RUN : ST_PAUSE;
                end
            end
`endif
            default: state_d = ST_PAUSE;
        endcase
        if (adv_c) begin
            offset_d = offset_step_c;
        end
        codes_d = pattern(offset_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_PAUSE;
            offset_q <= 2'd0;
            step_q   <= 1'b0;
            tick     <= 1'b0;
            codes    <= pattern(2'd0);
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            step_q   <= step;
            tick     <= adv_c;
            codes    <= codes_d;
        end
    end

`ifdef SCROLL_BLINK_EN
    // Blank during blink periods 1 and 3 (period_q 0 and 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= 2'd0;
            blank    <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_BLINK)) begin
            period_q <= 2'd0;
            blank    <= '1;
        end else if ((state_q == ST_BLINK) && tc_c) begin
            period_q <= period_q + 2'd1;
            blank    <= {NUM_DISP{period_q == 2'd1}};
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_char_scroller.sv
// Scoreboard bench for char_scroller (NUM_DISP=4, TICK_DIV=4); covers the SCROLL_BLINK_EN build too.
module tb_char_scroller;

    localparam int unsigned ND = 4;
    localparam int unsigned TD = 4;

    typedef struct {
        logic [7:0] codes;
        int         cyc;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       run  = 1'b0;
    logic       dir  = 1'b0;
    logic       step = 1'b0;
    logic [7:0] codes;
    logic       tick;
    logic [3:0] blank;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   ticks = 0;
    logic [1:0] m_off = 2'd0;
    exp_t sb[$];

    char_scroller #(.NUM_DISP(ND), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .dir   (dir),
        .step  (step),
        .codes (codes),
        .tick  (tick),
        .blank (blank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Leftmost display shows message[off], then message[off+1], ...
    function automatic logic [7:0] exp_codes(input logic [1:0] off);
        logic [1:0] msg [4];
        logic [1:0] p;
        logic [7:0] r;
        msg = '{2'b00, 2'b01, 2'b10, 2'b11};
        r = '0;
        for (int k = 0; k < 4; k++) begin
            p = off + 2'(k);
            r[2*(3-k) +: 2] = msg[p];
        end
        return r;
    endfunction

    task automatic push(input logic d, input int at);
        exp_t e;
        m_off   = d ? m_off - 2'd1 : m_off + 2'd1;
        e.codes = exp_codes(m_off);
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic drive();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_codes", 32'(codes), 32'h1B);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        m_off = 2'd0;
        sb.delete();
        drive();
        drive();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            drive();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (tick) begin
            ticks++;
            if (sb.size() == 0) begin
                check("unexpected_tick", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("tick_cyc", cyc, e.cyc);
                check("codes", 32'(codes), 32'(e.codes));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int c0;
        int t0;
        int endc;
        logic [3:0] eb;

        #3;
        do_reset();

        // Auto-scroll left through a full message wrap
        drive();
        c0  = cyc;
        run = 1'b1;
        dir = 1'b0;
        for (int k = 1; k <= 4; k++) push(1'b0, c0 + 1 + 4*k);
`ifdef SCROLL_BLINK_EN
        push(1'b0, c0 + 37);
        endc = c0 + 38;
`else
        endc = c0 + 18;
`endif
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            eb = 4'h0;
`ifdef SCROLL_BLINK_EN
            if (cyc >= c0 + 17 && cyc < c0 + 33 && (((cyc - c0 - 17) / 4) % 2) == 0) eb = 4'hF;
`endif
            check("blank", 32'(blank), 32'(eb));
            if (cyc >= endc) break;
        end
        drive();
        run = 1'b0;
        check("drain_left", sb.size(), 0);
        repeat (3) drive();

        // Auto-scroll right from reset
        do_reset();
        drive();
        c0  = cyc;
        run = 1'b1;
        dir = 1'b1;
        push(1'b1, c0 + 5);
        drain(20);
        run = 1'b0;
        check("codes_right", 32'(codes), 32'hC6);
        repeat (3) drive();

        // Paused stepping: held step gives one step, a second pulse another
        do_reset();
        drive();
        dir  = 1'b0;
        t0   = ticks;
        c0   = cyc;
        step = 1'b1;
        push(1'b0, c0 + 1);
        repeat (5) drive();
        step = 1'b0;
        repeat (2) drive();
        c0   = cyc;
        step = 1'b1;
        push(1'b0, c0 + 1);
        drive();
        step = 1'b0;
        drain(10);
        repeat (3) drive();
        check("step_ticks", ticks - t0, 2);
        check("codes_step", 32'(codes), 32'hB1);

        // Step edges with run rising and while running are ignored
        drive();
        c0   = cyc;
        run  = 1'b1;
        step = 1'b1;
        push(1'b0, c0 + 5);
        drive();
        step = 1'b0;
        drive();
        step = 1'b1;
        drive();
        step = 1'b0;
        drain(20);
        run = 1'b0;
        repeat (4) drive();

        // Reset at prescaler count 2 abandons the count
        drive();
        run = 1'b1;
        repeat (3) drive();
        run = 1'b0;
        do_reset();
        drive();
        c0  = cyc;
        run = 1'b1;
        push(1'b0, c0 + 5);
        drain(20);
        run = 1'b0;
        repeat (3) drive();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
